// File: rtl/bsg_channel_tunnel_rx_pkg.sv
// Shared types and width helpers for the channel-tunnel receive demux.
// Credit packets pack one count field per channel, channel 0 in the LSBs.
package bsg_channel_tunnel_rx_pkg;

  typedef enum logic [1:0] {
    CT_DATA    = 2'd0,
    CT_CREDIT  = 2'd1,
    CT_ILLEGAL = 2'd2
  } ct_kind_e;

  function automatic int ct_tag_width_f(int num_in);
    return $clog2(num_in + 1);
  endfunction

  function automatic int ct_cnt_width_f(int credits);
    return $clog2(credits + 1);
  endfunction

  function automatic int ct_pkt_width_f(int num_in, int cnt_w);
    return num_in * cnt_w;
  endfunction

  function automatic int ct_field_lsb_f(int ch, int cnt_w);
    return ch * cnt_w;
  endfunction

endpackage

// File: rtl/bsg_channel_tunnel_rx_buf.sv
// One-channel FIFO with registered full/empty flags.
// A written word becomes visible on v_o the cycle after the write.
module bsg_channel_tunnel_rx_buf #(
  parameter int width_p = 32,
  parameter int depth_p = 64
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               full_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int aw_lp = (depth_p > 1) ? $clog2(depth_p) : 1;
  localparam int cw_lp = $clog2(depth_p + 1);
  localparam logic [aw_lp-1:0] last_lp = aw_lp'(depth_p - 1);
  localparam logic [cw_lp-1:0] depth_lp = cw_lp'(depth_p);

  logic [width_p-1:0] mem_q [depth_p];
  logic [aw_lp-1:0] wptr_q, wptr_d;
  logic [aw_lp-1:0] rptr_q, rptr_d;
  logic [cw_lp-1:0] cnt_q, cnt_d;
  logic full_q, empty_q;
  logic enq, deq;

  assign enq = v_i & ~full_q;
  assign deq = yumi_i & ~empty_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (enq)
      wptr_d = (wptr_q == last_lp) ? '0 : wptr_q + aw_lp'(1);
    if (deq)
      rptr_d = (rptr_q == last_lp) ? '0 : rptr_q + aw_lp'(1);
    cnt_d = cnt_q + cw_lp'(enq) - cw_lp'(deq);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == depth_lp);
      empty_q <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq)
      mem_q[wptr_q] <= data_i;
  end

  assign full_o = full_q;
  assign v_o    = ~empty_q;
  assign data_o = mem_q[rptr_q];

endmodule

// File: rtl/bsg_channel_tunnel_rx_demux.sv
// Channel-tunnel receive demux: steers tagged words to channel FIFOs and
// returns credits. Optional BSG_CT_RX_DEMUX_ERR_EN adds a sticky err_o.
module bsg_channel_tunnel_rx_demux
  import bsg_channel_tunnel_rx_pkg::*;
#(
  parameter int width_p = 32,
  parameter int num_in_p = 3,
  parameter int remote_credits_p = 64,
  parameter int lg_credit_decimation_p = 4,
  localparam int tag_width_lp = ct_tag_width_f(num_in_p),
  localparam int cnt_width_lp = ct_cnt_width_f(remote_credits_p),
  localparam int pkt_width_lp = ct_pkt_width_f(num_in_p, cnt_width_lp)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          multi_v_i,
  input  logic [width_p+tag_width_lp-1:0] multi_data_i,
  output logic                          multi_yumi_o,
  output logic [num_in_p-1:0]           v_o,
  output logic [num_in_p*width_p-1:0]   data_o,
  input  logic [num_in_p-1:0]           yumi_i,
  output logic                          credit_send_v_o,
  output logic [pkt_width_lp-1:0]       credit_send_data_o,
  input  logic                          credit_send_yumi_i,
  output logic                          credit_recv_v_o,
  output logic [pkt_width_lp-1:0]       credit_recv_data_o
`ifdef BSG_CT_RX_DEMUX_ERR_EN
  ,
  output logic                          err_o
`endif
);

  if (width_p < pkt_width_lp) begin : g_bad_width
    $error("width_p too narrow for credit packet");
  end

  localparam logic [tag_width_lp-1:0] num_tag_lp = tag_width_lp'(num_in_p);
  localparam logic [cnt_width_lp-1:0] thresh_lp =
    cnt_width_lp'(2 ** lg_credit_decimation_p);

  logic [tag_width_lp-1:0] tag;
  logic [width_p-1:0] payload;
  ct_kind_e kind;
  logic [num_in_p-1:0] full, enq;
  logic full_sel;

  assign tag     = multi_data_i[width_p +: tag_width_lp];
  assign payload = multi_data_i[width_p-1:0];

  always_comb begin
    kind = CT_ILLEGAL;
    if (tag < num_tag_lp)
      kind = CT_DATA;
    else if (tag == num_tag_lp)
      kind = CT_CREDIT;
  end

  always_comb begin
    full_sel = 1'b0;
    for (int i = 0; i < num_in_p; i++)
      if (tag == tag_width_lp'(i))
        full_sel = full[i];
  end

  // Credit and illegal words are always consumed; data waits for space.
  always_comb begin
    multi_yumi_o = multi_v_i;
    unique case (1'b1)
      (kind == CT_DATA): multi_yumi_o = multi_v_i & ~full_sel;
      default:           multi_yumi_o = multi_v_i;
    endcase
  end

  for (genvar i = 0; i < num_in_p; i++) begin : g_ch
    assign enq[i] = multi_v_i & (kind == CT_DATA)
                  & (tag == tag_width_lp'(i)) & ~full[i];

    bsg_channel_tunnel_rx_buf #(
      .width_p(width_p),
      .depth_p(remote_credits_p)
    ) u_buf (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .v_i    (enq[i]),
      .data_i (payload),
      .full_o (full[i]),
      .v_o    (v_o[i]),
      .data_o (data_o[i*width_p +: width_p]),
      .yumi_i (yumi_i[i])
    );
  end

  logic recv_v_q, recv_v_d;
  logic [pkt_width_lp-1:0] recv_data_q, recv_data_d;

  always_comb begin
    recv_v_d    = multi_v_i & (kind == CT_CREDIT);
    recv_data_d = recv_data_q;
    if (recv_v_d)
      recv_data_d = payload[pkt_width_lp-1:0];
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      recv_v_q    <= 1'b0;
      recv_data_q <= '0;
    end else begin
      recv_v_q    <= recv_v_d;
      recv_data_q <= recv_data_d;
    end
  end

  assign credit_recv_v_o    = recv_v_q;
  assign credit_recv_data_o = recv_data_q;

  logic [num_in_p-1:0][cnt_width_lp-1:0] pending_q, pending_d;
  logic [num_in_p-1:0][cnt_width_lp-1:0] sent_q, sent_d;
  logic send_v_q, send_v_d;
  logic taken, over;

  assign taken = credit_send_yumi_i & send_v_q;

  // An offered packet is frozen until taken; otherwise it tracks the counters.
  always_comb begin
    over = 1'b0;
    for (int i = 0; i < num_in_p; i++) begin
      pending_d[i] = pending_q[i] + cnt_width_lp'(yumi_i[i]);
      if (taken)
        pending_d[i] = pending_d[i] - sent_q[i];
      over = over | (pending_d[i] >= thresh_lp);
    end
    send_v_d = send_v_q;
    sent_d   = sent_q;
    if (!send_v_q || taken) begin
      send_v_d = over;
      sent_d   = pending_d;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      pending_q <= '0;
      sent_q    <= '0;
      send_v_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      sent_q    <= sent_d;
      send_v_q  <= send_v_d;
    end
  end

  assign credit_send_v_o = send_v_q;

  for (genvar i = 0; i < num_in_p; i++) begin : g_pack
    assign credit_send_data_o[ct_field_lsb_f(i, cnt_width_lp) +: cnt_width_lp] =
      sent_q[i];
  end

`ifdef BSG_CT_RX_DEMUX_ERR_EN
  logic err_q, err_set;

  assign err_set = multi_v_i & ((kind == CT_ILLEGAL)
                 | ((kind == CT_DATA) & full_sel));

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)
      err_q <= 1'b0;
    else if (err_set)
      err_q <= 1'b1;
  end

  assign err_o = err_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_i && err_set && !err_q)
      $error("channel tunnel rx: illegal tag or credit overflow");
  end
`endif
`endif

endmodule

// File: tb/tb_bsg_channel_tunnel_rx_demux.sv
// Randomized bench for bsg_channel_tunnel_rx_demux against a queue model.
// Honors BSG_CT_RX_DEMUX_ERR_EN for the err_o port.
module tb_bsg_channel_tunnel_rx_demux;

  localparam int W = 32;
  localparam int N = 3;
  localparam int C = 7;
  localparam int PW = N * C;
  localparam int TH = 16;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic reset_i;
  logic multi_v_i;
  logic [W+1:0] multi_data_i;
  logic multi_yumi_o;
  logic [N-1:0] v_o;
  logic [N*W-1:0] data_o;
  logic [N-1:0] yumi_i;
  logic credit_send_v_o;
  logic [PW-1:0] credit_send_data_o;
  logic credit_send_yumi_i;
  logic credit_recv_v_o;
  logic [PW-1:0] credit_recv_data_o;
`ifdef BSG_CT_RX_DEMUX_ERR_EN
  logic err_o;
`endif

  always #5 clk = ~clk;

  bsg_channel_tunnel_rx_demux dut (
    .clk_i             (clk),
    .reset_i           (reset_i),
    .multi_v_i         (multi_v_i),
    .multi_data_i      (multi_data_i),
    .multi_yumi_o      (multi_yumi_o),
    .v_o               (v_o),
    .data_o            (data_o),
    .yumi_i            (yumi_i),
    .credit_send_v_o   (credit_send_v_o),
    .credit_send_data_o(credit_send_data_o),
    .credit_send_yumi_i(credit_send_yumi_i),
    .credit_recv_v_o   (credit_recv_v_o),
    .credit_recv_data_o(credit_recv_data_o)
`ifdef BSG_CT_RX_DEMUX_ERR_EN
    ,
    .err_o             (err_o)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: per-channel word queues, outstanding credit counts,
  // the credit packet on offer, and the last received credit packet.
  logic [W-1:0] q [N][$];
  int pend [N];
  int pkt [N];
  bit pkt_v;
  bit rv;
  logic [PW-1:0] rd;
  bit err_e;

  task automatic reset_model();
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      pend[i] = 0;
      pkt[i] = 0;
    end
    pkt_v = 0;
    rv = 0;
    rd = '0;
    err_e = 0;
  endtask

  function automatic logic [N-1:0] rand_yumi();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++)
      r[i] = (q[i].size() > 0) && ($urandom_range(1) == 1);
    return r;
  endfunction

  task automatic cycle(input bit mv, input logic [1:0] tg,
                       input logic [W-1:0] pl, input logic [N-1:0] yu,
                       input bit csy);
    bit ey;
    bit any;
    int t;
    t = int'(tg);
    multi_v_i = mv;
    multi_data_i = {tg, pl};
    yumi_i = yu;
    credit_send_yumi_i = csy;
    #4;
    if (t < N) ey = mv && (q[t].size() < DEPTH);
    else ey = mv;
    chk("multi_yumi", multi_yumi_o, ey);
    for (int i = 0; i < N; i++) begin
      chk("v_o", v_o[i], q[i].size() > 0);
      if (q[i].size() > 0)
        chk("data_o", data_o[i*W +: W], q[i][0]);
      chk("send_field", credit_send_data_o[i*C +: C],
          pkt_v ? pkt[i] : pend[i]);
    end
    chk("send_v", credit_send_v_o, pkt_v);
    chk("recv_v", credit_recv_v_o, rv);
    if (rv)
      chk("recv_data", credit_recv_data_o, rd);
`ifdef BSG_CT_RX_DEMUX_ERR_EN
    chk("err_o", err_o, err_e);
    if (mv && t < N && q[t].size() >= DEPTH) err_e = 1;
    if (mv && t > N) err_e = 1;
`endif
    for (int i = 0; i < N; i++)
      if (yu[i]) begin
        void'(q[i].pop_front());
        pend[i]++;
      end
    if (ey && t < N)
      q[t].push_back(pl);
    if (pkt_v && csy)
      for (int i = 0; i < N; i++)
        pend[i] -= pkt[i];
    if (!pkt_v || csy) begin
      any = 0;
      for (int i = 0; i < N; i++) begin
        pkt[i] = pend[i];
        if (pend[i] >= TH) any = 1;
      end
      pkt_v = any;
    end
    rv = ey && (t == N);
    if (rv)
      rd = pl[PW-1:0];
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 2'd0, '0, '0, 0);
  endtask

  task automatic flush();
    for (int k = 0; k < 10 && pkt_v; k++)
      cycle(0, 2'd0, '0, '0, 1);
  endtask

  logic [W-1:0] cp;

  initial begin
    reset_i = 1'b0;
    multi_v_i = 1'b0;
    multi_data_i = '0;
    yumi_i = '0;
    credit_send_yumi_i = 1'b0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst v_o", v_o, 0);
    chk("rst send_v", credit_send_v_o, 0);
    chk("rst send_data", credit_send_data_o, 0);
    chk("rst recv_v", credit_recv_v_o, 0);
    chk("rst recv_data", credit_recv_data_o, 0);
    chk("rst multi_yumi", multi_yumi_o, 0);
    reset_i = 1'b1;

    cycle(1, 2'd1, 32'hA5A5_0001, '0, 0);
    chk("t1 v_o", v_o, 3'b010);
    chk("t1 data", data_o[W +: W], 32'hA5A5_0001);
    cycle(0, 2'd0, '0, 3'b010, 0);

    for (int k = 0; k < DEPTH; k++)
      cycle(1, 2'd0, $urandom, '0, 0);
    cycle(1, 2'd0, 32'h6565_0001, '0, 0);
    cycle(1, 2'd0, 32'h6565_0001, 3'b001, 0);
    cycle(1, 2'd0, 32'h6565_0001, '0, 0);
    for (int k = 0; k < 100 && q[0].size() > 0; k++)
      cycle(0, 2'd0, '0, 3'b001, pkt_v);
    flush();

    for (int k = 0; k < 17; k++)
      cycle(1, 2'd2, $urandom, '0, 0);
    for (int k = 0; k < 16; k++)
      cycle(0, 2'd0, '0, 3'b100, 0);
    chk("ch2 send_v", credit_send_v_o, 1);
    chk("ch2 field16", credit_send_data_o[2*C +: C], 16);
    cycle(0, 2'd0, '0, 3'b100, 1);
    chk("ch2 field1", credit_send_data_o[2*C +: C], 1);
    chk("ch2 send_v off", credit_send_v_o, 0);

    cp = {11'h5A5, 7'd5, 7'd0, 7'd9};
    cycle(1, 2'd3, cp, '0, 0);
    chk("crd v", credit_recv_v_o, 1);
    chk("crd ch0", credit_recv_data_o[0 +: C], 9);
    chk("crd ch1", credit_recv_data_o[C +: C], 0);
    chk("crd ch2", credit_recv_data_o[2*C +: C], 5);
    cycle(1, 2'd3, {11'h0, 7'd1, 7'd2, 7'd3}, '0, 0);
    chk("crd v2", credit_recv_v_o, 1);
    idle(2);

    for (int k = 0; k < 3000; k++)
      cycle($urandom_range(1) == 1, 2'($urandom_range(3)), $urandom,
            rand_yumi(), pkt_v && ($urandom_range(1) == 1));

    flush();
    for (int k = 0; k < 16; k++)
      cycle(1, 2'd1, $urandom, '0, 0);
    for (int k = 0; k < 16; k++)
      cycle(0, 2'd0, '0, 3'b010, 0);
    for (int k = 0; k < 10; k++)
      cycle(1, 2'd0, $urandom, '0, 0);
    chk("pre-rst send_v", credit_send_v_o, 1);
    chk("pre-rst v0", v_o[0], 1);
    multi_v_i = 1'b0;
    yumi_i = '0;
    credit_send_yumi_i = 1'b0;
    #2;
    reset_i = 1'b0;
    #1;
    chk("mid-rst v_o", v_o, 0);
    chk("mid-rst send_v", credit_send_v_o, 0);
    chk("mid-rst send_data", credit_send_data_o, 0);
    chk("mid-rst recv_v", credit_recv_v_o, 0);
    @(posedge clk);
    #1;
    reset_i = 1'b1;
    reset_model();
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
